// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared types and constants for the serial frame receiver.
// Line levels, FSM state encoding and the parity helper used by sipo_frame_ctrl.
package sipo_pkg;

   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;
   localparam logic IDLE_LVL  = 1'b1;
   localparam int   MAX_WIDTH = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SHIFT  = 3'd1,
      PARITY = 3'd2,
      STOP   = 3'd3,
      BREAK  = 3'd4
   } state_t;

   // XOR reduction of a zero-extended word; zero padding leaves the result unchanged.
   function automatic logic par_xor(input logic [MAX_WIDTH-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Parallel-side and strobe signals of the frame receiver bundled as one port.
// The master modport drives stimulus, the slave modport is the receiver itself.
interface sipo_frame_ctrl_if #(parameter int WIDTH = 4);
   logic             bit_en;
   logic             si;
   logic             out_ready;
   logic             err_clr;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             parity_err;
   logic             frame_err;
   logic             overrun;
   logic             busy;

   modport master (
      output bit_en, si, out_ready, err_clr,
      input  out_data, out_valid, parity_err, frame_err, overrun, busy
   );

   modport slave (
      input  bit_en, si, out_ready, err_clr,
      output out_data, out_valid, parity_err, frame_err, overrun, busy
   );
endinterface

// File: rtl/sipo_shift_core.sv
// WIDTH-bit right-shift register: the serial bit enters at the MSB, so the
// first bit received ends up in the LSB after WIDTH shifts.
module sipo_shift_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             i_shift,
   input  logic             i_clr,
   input  logic             i_si,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // Shift register with synchronous clear taking priority over shift.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_q <= '0;
      end else if (i_clr) begin
         r_q <= '0;
      end else if (i_shift) begin
         r_q <= {i_si, r_q[WIDTH-1:1]};
      end else begin
         r_q <= r_q;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, optional even
// parity, stop bit; good words land in a one-entry valid/ready output buffer.
module sipo_frame_ctrl
   import sipo_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic             clk,
   input  logic             clear_n,
   sipo_frame_ctrl_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic             r_pbit;
   logic             w_pbit_nxt;
   logic             w_shift;
   logic             w_sclr;
   logic             w_commit;
   logic             w_perr;
   logic             w_ferr;
   logic             w_par_ok;
   logic             w_accept;
   logic [WIDTH-1:0] w_data;

   logic [WIDTH-1:0] r_out_data;
   logic             r_out_valid;
   logic             r_parity_err;
   logic             r_frame_err;
   logic             r_overrun;
   logic             r_busy;

   sipo_shift_core #(.WIDTH(WIDTH)) u_shift (
      .clk     (clk),
      .clear_n (clear_n),
      .i_shift (w_shift),
      .i_clr   (w_sclr),
      .i_si    (bus.si),
      .o_q     (w_data)
   );

   assign w_par_ok = PARITY_EN ? (par_xor(MAX_WIDTH'(w_data)) == r_pbit) : 1'b1;
   assign w_accept = r_out_valid & bus.out_ready;

   // FSM state, bit counter and captured parity bit.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_pbit  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
         r_pbit  <= w_pbit_nxt;
      end
   end

   // Next-state and strobe decode; nothing advances without bit_en.
   always_comb begin
      w_next     = r_state;
      w_cnt_nxt  = r_cnt;
      w_pbit_nxt = r_pbit;
      w_shift    = 1'b0;
      w_sclr     = 1'b0;
      w_commit   = 1'b0;
      w_perr     = 1'b0;
      w_ferr     = 1'b0;
      if (bus.bit_en) begin
         case (r_state)
            IDLE: begin
               if (bus.si == START_LVL) begin
                  w_next    = SHIFT;
                  w_cnt_nxt = '0;
                  w_sclr    = 1'b1;
               end else begin
                  w_next = IDLE;
               end
            end
            SHIFT: begin
               w_shift   = 1'b1;
               w_cnt_nxt = r_cnt + CW'(1);
               if (r_cnt == CW'(WIDTH - 1)) begin
                  if (PARITY_EN) begin
                     w_next = PARITY;
                  end else begin
                     w_next = STOP;
                  end
               end else begin
                  w_next = SHIFT;
               end
            end
            PARITY: begin
               w_pbit_nxt = bus.si;
               w_next     = STOP;
            end
            STOP: begin
               if (bus.si != STOP_LVL) begin
                  w_ferr = 1'b1;
                  w_next = BREAK;
               end else if (w_par_ok) begin
                  w_commit = 1'b1;
                  w_next   = IDLE;
               end else begin
                  w_perr = 1'b1;
                  w_next = IDLE;
               end
            end
            BREAK: begin
               // A held-low line must return high before a new start bit counts.
               if (bus.si == IDLE_LVL) begin
                  w_next = IDLE;
               end else begin
                  w_next = BREAK;
               end
            end
            default: begin
               w_next = IDLE;
            end
         endcase
      end else begin
         w_next = r_state;
      end
   end

   // Output buffer, sticky overrun and one-cycle error pulses.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_out_data   <= '0;
         r_out_valid  <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         if (w_commit && (!r_out_valid || bus.out_ready)) begin
            r_out_data  <= w_data;
            r_out_valid <= 1'b1;
         end else if (w_accept) begin
            r_out_valid <= 1'b0;
         end else begin
            r_out_valid <= r_out_valid;
         end
         if (w_commit && r_out_valid && !bus.out_ready) begin
            r_overrun <= 1'b1;
         end else if (bus.err_clr) begin
            r_overrun <= 1'b0;
         end else begin
            r_overrun <= r_overrun;
         end
         r_parity_err <= w_perr;
         r_frame_err  <= w_ferr;
         r_busy       <= (w_next != IDLE);
      end
   end

   assign bus.out_data   = r_out_data;
   assign bus.out_valid  = r_out_valid;
   assign bus.parity_err = r_parity_err;
   assign bus.frame_err  = r_frame_err;
   assign bus.overrun    = r_overrun;
   assign bus.busy       = r_busy;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed self-checking bench for sipo_frame_ctrl (WIDTH=4, even parity).
// Inputs change 1ns after a rising edge; outputs are checked at that same point.
module tb_sipo_frame_ctrl;

   logic clk;
   logic clear_n;
   int   n_checks;
   int   n_errors;

   sipo_frame_ctrl_if #(.WIDTH(4)) bus ();

   sipo_frame_ctrl #(.WIDTH(4), .PARITY_EN(1'b1)) dut (
      .clk     (clk),
      .clear_n (clear_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Present en/si for one clock, return 1ns after the sampling edge.
   task automatic tick(input logic en, input logic b);
      bus.bit_en = en;
      bus.si     = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [3:0] d, input logic p, input logic stp);
      tick(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) tick(1'b1, d[i]);
      tick(1'b1, p);
      tick(1'b1, stp);
      bus.bit_en = 1'b0;
      bus.si     = 1'b1;
   endtask

   task automatic sparse_bit(input logic b);
      tick(1'b0, b);
      tick(1'b0, b);
      tick(1'b0, b);
      tick(1'b1, b);
   endtask

   task automatic accept_word();
      bus.out_ready = 1'b1;
      tick(1'b0, 1'b1);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      clear_n       = 1'b0;
      bus.bit_en    = 1'b0;
      bus.si        = 1'b1;
      bus.out_ready = 1'b0;
      bus.err_clr   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_data",  32'(bus.out_data),  32'd0);
      check_eq("rst_busy",  32'(bus.busy),      32'd0);
      check_eq("rst_ovr",   32'(bus.overrun),   32'd0);
      clear_n = 1'b1;
      tick(1'b1, 1'b1);
      check_eq("idle_busy", 32'(bus.busy), 32'd0);

      // Good frame 1,0,1,1 with parity 1 -> 4'hD
      tick(1'b1, 1'b0);
      check_eq("start_busy", 32'(bus.busy), 32'd1);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      check_eq("pre_stop_valid", 32'(bus.out_valid), 32'd0);
      tick(1'b1, 1'b1);
      check_eq("good_valid", 32'(bus.out_valid),  32'd1);
      check_eq("good_data",  32'(bus.out_data),   32'hD);
      check_eq("good_perr",  32'(bus.parity_err), 32'd0);
      check_eq("good_ferr",  32'(bus.frame_err),  32'd0);
      check_eq("good_busy",  32'(bus.busy),       32'd0);
      accept_word();
      check_eq("accept_valid", 32'(bus.out_valid), 32'd0);

      // Parity error then recovery
      send_frame(4'hD, 1'b0, 1'b1);
      check_eq("perr_pulse", 32'(bus.parity_err), 32'd1);
      check_eq("perr_valid", 32'(bus.out_valid),  32'd0);
      tick(1'b0, 1'b1);
      check_eq("perr_clear", 32'(bus.parity_err), 32'd0);
      send_frame(4'h8, 1'b1, 1'b1);
      check_eq("after_perr_valid", 32'(bus.out_valid), 32'd1);
      check_eq("after_perr_data",  32'(bus.out_data),  32'h8);
      accept_word();

      // Frame error and break
      send_frame(4'hD, 1'b1, 1'b0);
      check_eq("ferr_pulse", 32'(bus.frame_err), 32'd1);
      check_eq("ferr_busy",  32'(bus.busy),      32'd1);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0);
         check_eq("brk_ferr",  32'(bus.frame_err), 32'd0);
         check_eq("brk_busy",  32'(bus.busy),      32'd1);
         check_eq("brk_valid", 32'(bus.out_valid), 32'd0);
      end
      tick(1'b1, 1'b1);
      check_eq("brk_exit_busy",  32'(bus.busy),      32'd0);
      check_eq("brk_exit_valid", 32'(bus.out_valid), 32'd0);
      send_frame(4'h3, 1'b0, 1'b1);
      check_eq("after_brk_data", 32'(bus.out_data), 32'h3);
      accept_word();

      // Overrun: D pending, 3 arrives without accept
      send_frame(4'hD, 1'b1, 1'b1);
      send_frame(4'h3, 1'b0, 1'b1);
      check_eq("ovr_data",  32'(bus.out_data),  32'hD);
      check_eq("ovr_flag",  32'(bus.overrun),   32'd1);
      check_eq("ovr_valid", 32'(bus.out_valid), 32'd1);
      tick(1'b0, 1'b1);
      check_eq("ovr_sticky", 32'(bus.overrun), 32'd1);
      bus.err_clr = 1'b1;
      tick(1'b0, 1'b1);
      bus.err_clr = 1'b0;
      check_eq("ovr_cleared", 32'(bus.overrun), 32'd0);

      // Accept in the same cycle as the stop sample of a new frame
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      bus.out_ready = 1'b1;
      tick(1'b1, 1'b1);
      bus.out_ready = 1'b0;
      bus.bit_en    = 1'b0;
      check_eq("simul_data",  32'(bus.out_data),  32'h3);
      check_eq("simul_valid", 32'(bus.out_valid), 32'd1);
      check_eq("simul_ovr",   32'(bus.overrun),   32'd0);

      // Sparse strobe with mid-frame reset; word 3 still pending
      sparse_bit(1'b0);
      check_eq("sparse_start_busy", 32'(bus.busy), 32'd1);
      sparse_bit(1'b1);
      tick(1'b0, 1'b1);
      #2;
      clear_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      check_eq("mid_rst_data",  32'(bus.out_data),  32'd0);
      check_eq("mid_rst_busy",  32'(bus.busy),      32'd0);
      #2;
      clear_n = 1'b1;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      check_eq("no_strobe_busy", 32'(bus.busy), 32'd0);
      tick(1'b1, 1'b0);
      check_eq("strobe_busy", 32'(bus.busy), 32'd1);
      sparse_bit(1'b0);
      sparse_bit(1'b0);
      sparse_bit(1'b0);
      sparse_bit(1'b1);
      sparse_bit(1'b1);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      check_eq("sparse_pre_stop", 32'(bus.out_valid), 32'd0);
      tick(1'b1, 1'b1);
      check_eq("sparse_valid", 32'(bus.out_valid), 32'd1);
      check_eq("sparse_data",  32'(bus.out_data),  32'h8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
